// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a-b LSB-first, one bit per clock.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request, sampled only while ready=1
//   a, b  - minuend / subtrahend, captured with start
//   ready - high in IDLE and DONE (start will be accepted)
//   busy  - high in RUN
//   done  - one-cycle pulse when diff/bout are newly valid
//   diff  - (a-b) mod 2^WIDTH, held until the next result
//   bout  - final borrow (a < b), held with diff
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    // Per-bit subtractor cell and the result register after shifting d in at the MSB.
    logic             d_c;
    logic             br_d;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        d_c   = a_q[0] ^ b_q[0] ^ br_q;
        br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_d = (res_q >> 1) | (WIDTH'(d_c) << (WIDTH - 1));
    end

    // Control, datapath and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        res_q   <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Last bit: publish the result straight from the cell outputs.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        state_q <= S_DONE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one start cycle; returns at the negedge after the accepting edge.
    task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges until done is seen (bounded); also counts cycles with ready low.
    task automatic wait_done(output int lat, output int rdy_low);
        lat     = 0;
        rdy_low = 0;
        while (done !== 1'b1 && lat < 50) begin
            if (ready === 1'b0) rdy_low++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic [WIDTH-1:0] ed, input logic eb, input string tag);
        int lat;
        int rl;
        launch(ta, tb_v);
        wait_done(lat, rl);
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_ready_low"}, 32'(rl), 32'd8);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int rl;
        int pulses;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic ops
        run_op(8'd200, 8'd55, 8'd145, 1'b0, "t1");
        run_op(8'd5,   8'd9,  8'd252, 1'b1, "t2a");
        run_op(8'd0,   8'd255, 8'd1,  1'b1, "t2b");
        run_op(8'hA5,  8'hA5,  8'd0,  1'b0, "t2c");

        // start during RUN is ignored
        launch(8'd100, 8'd1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a     = 8'd10;
        b     = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, rl);
        check("t3_latency", 32'(lat + 4), 32'd8);
        check("t3_diff", 32'(diff), 32'd99);
        check("t3_bout", 32'(bout), 32'd0);
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("t3_extra_pulses", 32'(pulses), 32'd0);

        // Back-to-back: start held in DONE
        launch(8'd20, 8'd5);
        wait_done(lat, rl);
        check("t4_first_diff", 32'(diff), 32'd15);
        start = 1'b1;
        a     = 8'd7;
        b     = 8'd7;
        @(negedge clk);
        start = 1'b0;
        check("t4_no_gap_busy", 32'(busy), 32'd1);
        wait_done(lat, rl);
        check("t4_pulse_spacing", 32'(lat + 1), 32'd9);
        check("t4_diff", 32'(diff), 32'd0);
        check("t4_bout", 32'(bout), 32'd0);
        @(negedge clk);

        // Asynchronous reset mid-RUN
        run_op(8'd9, 8'd4, 8'd5, 1'b0, "t5pre");
        launch(8'd50, 8'd3);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_diff", 32'(diff), 32'd0);
        check("t5_bout", 32'(bout), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(ready), 32'd1);
        check("t5_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("t5_no_pulse", 32'(pulses), 32'd0);
        run_op(8'd1, 8'd2, 8'd255, 1'b1, "t5post");

        // Random operands and gaps
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            launch(ra, rb);
            wait_done(lat, rl);
            check("rnd_latency", 32'(lat), 32'd8);
            check("rnd_diff", 32'(diff), 32'(8'(ra - rb)));
            check("rnd_bout", 32'(bout), (ra < rb) ? 32'd1 : 32'd0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
